clk_rst_seq: RTL and testbench

Parametrised clock-enable and reset sequencer for the single-PLL-clock design. It replaces ripple-divided clocks with phase-aligned clock enables, and replaces the single power-on reset counter with a per-domain, staggered reset release. It also handles PLL lock loss by re-asserting every domain reset and restarting the sequence. It sits directly behind the PLL and feeds every subsystem: CPU/main, TFT driver, and future peripherals.

---
 rtl/clk_rst_seq.sv | 160 ++++++++++++++++
 tb/tb_clk_rst_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: clock-enable generator and staggered per-domain reset sequencer.
// Replaces ripple-divided clocks with phase-aligned enables off the PLL clock and
// releases domain resets one by one once the PLL has been locked for RST_HOLD cycles.
// Loss of lock re-asserts every domain reset and restarts the whole sequence.
module clk_rst_seq #(
  parameter int unsigned NUM_EN      = 3,
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned RST_HOLD    = 15,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic [NUM_DOMAINS-1:0] dom_hold,
  output logic [NUM_EN-1:0]      ce,
  output logic [NUM_EN-1:0]      div_cnt,
  output logic [NUM_DOMAINS-1:0] rst,
  output logic                   seq_done,
  output logic                   lock_lost
);

  localparam int unsigned MaxCnt = (RST_HOLD > STAGGER) ? RST_HOLD : STAGGER;
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] StagLast = CNT_W'(STAGGER - 1);

  // Reject parameter sets the shared counter or the output encodings cannot cover.
  if (NUM_EN < 1 || NUM_EN > 8 || NUM_DOMAINS < 1 || NUM_DOMAINS > 8 ||
      RST_HOLD < 1 || STAGGER < 1 || (64'd1 << CNT_W) <= 64'(MaxCnt)) begin : gen_bad_params
    $error("clk_rst_seq: illegal parameter set");
  end

  typedef enum logic [1:0] {
    StWaitLock,
    StHold,
    StRelease,
    StRun
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, lock_s_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] released_q, released_d, released_next;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic [NUM_EN-1:0]      div_cnt_q, div_cnt_d;
  logic [NUM_EN-1:0]      ce_q, ce_d;
  logic                   seq_done_q, seq_done_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lock_loss, rel_now, rel_last, running_d;

  // Lock drop anywhere past WAIT_LOCK aborts the sequence.
  assign lock_loss = !lock_s_q && (state_q != StWaitLock);

  // Domains release in index order, so released bits form a thermometer code and the
  // next release simply shifts one more bit in.
  assign released_next = (released_q << 1) | NUM_DOMAINS'(1);
  assign rel_now       = (state_q == StRelease) && (cnt_q == '0);
  assign rel_last      = rel_now && released_next[NUM_DOMAINS-1];

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWaitLock;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; lock loss overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (lock_loss) begin
      state_d = StWaitLock;
    end else begin
      case (state_q)
        StWaitLock: if (lock_s_q) state_d = StHold;
        StHold:     if (cnt_q == HoldLast) state_d = StRelease;
        StRelease:  if (rel_last) state_d = StRun;
        StRun:      state_d = StRun;
        default:    state_d = StWaitLock;
      endcase
    end
  end

  // Counter, release bits, divider and registered output next-values.
  always_comb begin
    logic ones;
    cnt_d      = '0;
    released_d = released_q;
    div_cnt_d  = '0;
    ce_d       = '0;
    ones       = 1'b1;
    if (!lock_loss) begin
      case (state_q)
        StHold: begin
          cnt_d = (cnt_q == HoldLast) ? '0 : cnt_q + CNT_W'(1);
        end
        StRelease: begin
          cnt_d = (cnt_q == StagLast) ? '0 : cnt_q + CNT_W'(1);
          if (rel_now) released_d = released_next;
        end
        default: ;
      endcase
      if (state_q == StRelease || state_q == StRun) begin
        div_cnt_d = div_cnt_q + NUM_EN'(1);
      end
    end
    if (lock_loss || state_q == StWaitLock) begin
      released_d = '0;
    end
    running_d = (state_d == StRelease) || (state_d == StRun);
    // ce[k] fires when the low k+1 bits of the count are all ones.
    for (int k = 0; k < NUM_EN; k++) begin
      ones    = ones & div_cnt_d[k];
      ce_d[k] = running_d & ones;
    end
    rst_d       = dom_hold | ~released_d;
    seq_done_d  = (state_d == StRun);
    lock_lost_d = lock_lost_q | lock_loss;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      released_q  <= '0;
      rst_q       <= '1;
      div_cnt_q   <= '0;
      ce_q        <= '0;
      seq_done_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      released_q  <= released_d;
      rst_q       <= rst_d;
      div_cnt_q   <= div_cnt_d;
      ce_q        <= ce_d;
      seq_done_q  <= seq_done_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign ce        = ce_q;
  assign div_cnt   = div_cnt_q;
  assign rst       = rst_q;
  assign seq_done  = seq_done_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: default instance (2 domains, stagger 4) plus a 4-domain,
// stagger-1 instance sharing the same lock input. A cycle-based model predicts every
// output from the lock-acquire cycle W and the release offsets.
module tb_clk_rst_seq;

  localparam int Hold = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic [1:0] dom_hold = '0;
  logic [3:0] dom_hold4 = '0;

  logic [2:0] ce, div_cnt, ce4, div_cnt4;
  logic [1:0] rst;
  logic [3:0] rst4;
  logic       seq_done, lock_lost, seq_done4, lock_lost4;

  int nchk = 0;
  int nerr = 0;
  int dcyc = 0;
  int cyc  = 0;

  clk_rst_seq u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .dom_hold  (dom_hold),
    .ce        (ce),
    .div_cnt   (div_cnt),
    .rst       (rst),
    .seq_done  (seq_done),
    .lock_lost (lock_lost)
  );

  clk_rst_seq #(
    .NUM_EN     (3),
    .NUM_DOMAINS(4),
    .RST_HOLD   (15),
    .STAGGER    (1),
    .CNT_W      (8)
  ) u_dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .dom_hold  (dom_hold4),
    .ce        (ce4),
    .div_cnt   (div_cnt4),
    .rst       (rst4),
    .seq_done  (seq_done4),
    .lock_lost (lock_lost4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic       pl_hist [0:4095];
  logic [1:0] dh_hist [0:4095];
  logic [3:0] dh4_hist[0:4095];
  bit         m_active = 1'b0;
  bit         m_lost = 1'b0;
  int         m_w = 0;

  // Domain i is out of reset from cycle r+1+i*s unless its hold was set last cycle.
  function automatic logic [3:0] exp_rst(int c, int r, int nd, int s, logic [3:0] dh);
    logic [3:0] v;
    v = '1;
    for (int i = 0; i < nd; i++) v[i] = dh[i] | (c < r + 1 + i * s);
    return v;
  endfunction

  initial begin : cmp
    logic       ls;
    logic [3:0] e_rst2, e_rst4;
    logic [2:0] e_ce, e_div;
    logic       e_sd2, e_sd4;
    int         r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cyc      = 0;
        m_active = 1'b0;
        m_lost   = 1'b0;
      end else if (cyc > 4095) begin
        chk("history_overflow", 32'(cyc), 32'd4095);
      end else begin
        pl_hist[cyc]  = pll_locked;
        dh_hist[cyc]  = dom_hold;
        dh4_hist[cyc] = dom_hold4;
        ls = (cyc >= 2) ? pl_hist[cyc-2] : 1'b0;
        e_rst2 = '1; e_rst4 = '1; e_ce = '0; e_div = '0; e_sd2 = 1'b0; e_sd4 = 1'b0;
        if (m_active) begin
          r      = m_w + 1 + Hold;
          e_rst2 = exp_rst(cyc, r, 2, 4, {2'b00, dh_hist[cyc-1]});
          e_rst4 = exp_rst(cyc, r, 4, 1, dh4_hist[cyc-1]);
          e_sd2  = (cyc >= r + 1 + 4);
          e_sd4  = (cyc >= r + 1 + 3);
          if (cyc >= r) begin
            e_div = 3'((cyc - r) % 8);
            for (int k = 0; k < 3; k++) e_ce[k] = (((cyc - r + 1) % (2 << k)) == 0);
          end
        end
        chk("m_rst",        32'(rst),        32'(e_rst2[1:0]));
        chk("m_ce",         32'(ce),         32'(e_ce));
        chk("m_div_cnt",    32'(div_cnt),    32'(e_div));
        chk("m_seq_done",   32'(seq_done),   32'(e_sd2));
        chk("m_lock_lost",  32'(lock_lost),  32'(m_lost));
        chk("m_rst4",       32'(rst4),       32'(e_rst4));
        chk("m_ce4",        32'(ce4),        32'(e_ce));
        chk("m_div_cnt4",   32'(div_cnt4),   32'(e_div));
        chk("m_seq_done4",  32'(seq_done4),  32'(e_sd4));
        chk("m_lock_lost4", 32'(lock_lost4), 32'(m_lost));
        if (m_active && !ls) begin
          m_active = 1'b0;
          m_lost   = 1'b1;
        end else if (!m_active && ls) begin
          m_active = 1'b1;
          m_w      = cyc;
        end
        cyc++;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    dcyc++;
  endtask

  task automatic step_to(input int n);
    while (dcyc < n) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst"},       32'(rst),       32'h3);
    chk({tag, "_rst4"},      32'(rst4),      32'hf);
    chk({tag, "_ce"},        32'(ce),        32'h0);
    chk({tag, "_div"},       32'(div_cnt),   32'h0);
    chk({tag, "_seq_done"},  32'(seq_done),  32'h0);
    chk({tag, "_lock_lost"}, 32'(lock_lost), 32'h0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    dom_hold   = '0;
    dom_hold4  = '0;
    step();
    step();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    dcyc    = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    // Scenario A: clean lock, divider, lock loss and relock, reset mid-RELEASE.
    do_reset();
    pll_locked = 1'b1;
    step_to(17); chk("a17_rst", 32'(rst), 32'h3); chk("a17_div", 32'(div_cnt), 32'h0);
    step_to(18); chk("a18_rst", 32'(rst), 32'h3); chk("a18_ce", 32'(ce), 32'h0);
                 chk("a18_rst4", 32'(rst4), 32'hf);
    step_to(19); chk("a19_rst", 32'(rst), 32'h2); chk("a19_ce", 32'(ce), 32'h1);
                 chk("a19_div", 32'(div_cnt), 32'h1); chk("a19_rst4", 32'(rst4), 32'he);
    step_to(20); chk("a20_rst4", 32'(rst4), 32'hc);
    step_to(21); chk("a21_ce", 32'(ce), 32'h3); chk("a21_rst4", 32'(rst4), 32'h8);
                 chk("a21_sd4", 32'(seq_done4), 32'h0);
    step_to(22); chk("a22_sd", 32'(seq_done), 32'h0); chk("a22_rst", 32'(rst), 32'h2);
                 chk("a22_rst4", 32'(rst4), 32'h0); chk("a22_sd4", 32'(seq_done4), 32'h1);
    step_to(23); chk("a23_rst", 32'(rst), 32'h0); chk("a23_sd", 32'(seq_done), 32'h1);
    step_to(25); chk("a25_div", 32'(div_cnt), 32'h7); chk("a25_ce", 32'(ce), 32'h7);
    step_to(26); chk("a26_div", 32'(div_cnt), 32'h0);
    step_to(50); pll_locked = 1'b0;
    step_to(52); chk("a52_rst", 32'(rst), 32'h0); chk("a52_ll", 32'(lock_lost), 32'h0);
    step_to(53); chk("a53_rst", 32'(rst), 32'h3); chk("a53_ce", 32'(ce), 32'h0);
                 chk("a53_sd", 32'(seq_done), 32'h0); chk("a53_ll", 32'(lock_lost), 32'h1);
    step_to(60); pll_locked = 1'b1;
    step_to(78); chk("a78_rst", 32'(rst), 32'h3);
    step_to(79); chk("a79_rst", 32'(rst), 32'h2); chk("a79_ll", 32'(lock_lost), 32'h1);
    step_to(81); chk("a81_ce", 32'(ce), 32'h3); chk("a81_div", 32'(div_cnt), 32'h3);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");

    // Scenario B: dom_hold keeps domain 1 in reset without stalling the sequence.
    do_reset();
    pll_locked = 1'b1;
    dom_hold   = 2'b10;
    step_to(19); chk("b19_rst", 32'(rst), 32'h2);
    step_to(23); chk("b23_rst", 32'(rst), 32'h2); chk("b23_sd", 32'(seq_done), 32'h1);
    step_to(40); chk("b40_rst", 32'(rst), 32'h2); dom_hold = 2'b00;
    step_to(41); chk("b41_rst", 32'(rst), 32'h0);
    step_to(45); dom_hold = 2'b01;
    step_to(46); chk("b46_rst", 32'(rst), 32'h1); chk("b46_sd", 32'(seq_done), 32'h1);

    // Scenario C: one-cycle lock glitch during HOLD restarts the hold count.
    do_reset();
    pll_locked = 1'b1;
    step_to(5);  pll_locked = 1'b0;
    step_to(6);  pll_locked = 1'b1;
    step_to(8);  chk("c8_ll", 32'(lock_lost), 32'h1);
    step_to(24); chk("c24_rst", 32'(rst), 32'h3);
    step_to(25); chk("c25_rst", 32'(rst), 32'h2);
    step_to(29); chk("c29_rst", 32'(rst), 32'h0); chk("c29_sd", 32'(seq_done), 32'h1);

    // Random phase: lock drops/reacquires and hold requests checked by the model.
    do_reset();
    pll_locked = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step();
      if (pll_locked) pll_locked = ($urandom_range(0, 59) != 0);
      else            pll_locked = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) dom_hold  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) dom_hold4 = 4'($urandom_range(0, 15));
    end
    step();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
